// File: rtl/ps2_arrow_decoder.sv
// PS/2 set-2 arrow-key decoder: tracks held state of the four extended arrow keys.
// Optional PS2_KEY_EVENT_EN adds one-cycle press/release event pulses.
module ps2_arrow_decoder #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       left,
    output logic       down,
    output logic       right,
    output logic       up,
    output logic       seq_timeout
`ifdef PS2_KEY_EVENT_EN
    ,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse
`endif
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, EXT, EXT_BRK, BRK} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [3:0]      keys_reg, keys_next;   // {up,right,down,left}
    logic            seq_timeout_reg, seq_timeout_next;
    logic            timeout_hit;
    logic            is_arrow;
    logic [1:0]      arrow_idx;

    always_comb begin
        is_arrow  = 1'b1;
        arrow_idx = 2'd0;
        case (byte_data)
            8'h6B:   arrow_idx = 2'd0;
            8'h72:   arrow_idx = 2'd1;
            8'h74:   arrow_idx = 2'd2;
            8'h75:   arrow_idx = 2'd3;
            default: is_arrow  = 1'b0;
        endcase
    end

    // The TIMEOUT-th consecutive idle cycle aborts; a byte on that cycle takes priority.
    assign timeout_hit = (state_reg != IDLE) && !byte_valid && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            keys_reg        <= '0;
            seq_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            keys_reg        <= keys_next;
            seq_timeout_reg <= seq_timeout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (timeout_hit) begin
            state_next = IDLE;
        end else if (byte_valid) begin
            case (state_reg)
                IDLE: begin
                    if (byte_data == 8'hE0)      state_next = EXT;
                    else if (byte_data == 8'hF0) state_next = BRK;
                end
                EXT: begin
                    if (byte_data == 8'hF0)      state_next = EXT_BRK;
                    else if (byte_data == 8'hE0) state_next = EXT;
                    else                         state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        keys_next        = keys_reg;
        seq_timeout_next = timeout_hit;
        if (state_reg == IDLE || byte_valid || timeout_hit)
            cnt_next = '0;
        else
            cnt_next = cnt_reg + CW'(1);
        if (byte_valid) begin
            case (state_reg)
                IDLE:    if (byte_data == 8'hAA) keys_next = 4'b0000;
                EXT:     if (is_arrow) keys_next[arrow_idx] = 1'b1;
                EXT_BRK: if (is_arrow) keys_next[arrow_idx] = 1'b0;
                default: ;
            endcase
        end
    end

    assign left        = keys_reg[0];
    assign down        = keys_reg[1];
    assign right       = keys_reg[2];
    assign up          = keys_reg[3];
    assign seq_timeout = seq_timeout_reg;

`ifdef PS2_KEY_EVENT_EN
    logic [3:0] press_pulse_reg, release_pulse_reg;

    // Edge detection on the next-state keys keeps pulses aligned with the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            press_pulse_reg   <= '0;
            release_pulse_reg <= '0;
        end else begin
            press_pulse_reg   <= keys_next & ~keys_reg;
            release_pulse_reg <= keys_reg & ~keys_next;
        end
    end

    assign press_pulse   = press_pulse_reg;
    assign release_pulse = release_pulse_reg;
`endif

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Self-checking bench for ps2_arrow_decoder: directed scenarios then random byte streams,
// compared against a prefix-queue reference model of the scancode rules.
module tb_ps2_arrow_decoder;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       left, down, right, up, seq_timeout;
`ifdef PS2_KEY_EVENT_EN
    logic [3:0] press_pulse, release_pulse;
`endif

    ps2_arrow_decoder #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .left       (left),
        .down       (down),
        .right      (right),
        .up         (up),
        .seq_timeout(seq_timeout)
`ifdef PS2_KEY_EVENT_EN
        ,
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: bytes of the pending multi-byte prefix, key levels {up,right,down,left}.
    logic [7:0] pfx[$];
    logic [3:0] mkeys, mprev;
    logic       mto;
    int         idle;
    int         vectors = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int arrow(input logic [7:0] b);
        case (b)
            8'h6B:   return 0;
            8'h72:   return 1;
            8'h74:   return 2;
            8'h75:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        pfx.delete();
        mkeys = 4'b0;
        mprev = 4'b0;
        mto   = 1'b0;
        idle  = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int a;
        a = arrow(b);
        if (pfx.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) pfx.push_back(b);
            else if (b == 8'hAA)          mkeys = 4'b0;
        end else if (pfx.size() == 1 && pfx[0] == 8'hF0) begin
            pfx.delete();
        end else if (pfx.size() == 1) begin
            if (b == 8'hF0) pfx.push_back(b);
            else if (b != 8'hE0) begin
                if (a >= 0) mkeys[a] = 1'b1;
                pfx.delete();
            end
        end else begin
            if (a >= 0) mkeys[a] = 1'b0;
            pfx.delete();
        end
        idle = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".keys"}, {4'b0, up, right, down, left}, {4'b0, mkeys});
        chk({tag, ".to"}, {7'b0, seq_timeout}, {7'b0, mto});
`ifdef PS2_KEY_EVENT_EN
        chk({tag, ".press"}, {4'b0, press_pulse}, {4'b0, mkeys & ~mprev});
        chk({tag, ".release"}, {4'b0, release_pulse}, {4'b0, mprev & ~mkeys});
`endif
    endtask

    // One clock cycle: drive inputs, advance model with the DUT edge, sample 1 time unit later.
    task automatic step(input logic v, input logic [7:0] d, input string tag);
        byte_valid = v;
        byte_data  = d;
        mprev      = mkeys;
        mto        = 1'b0;
        @(posedge clk);
        if (v) model_byte(d);
        else if (pfx.size() != 0) begin
            idle++;
            if (idle == TO) begin
                pfx.delete();
                mto  = 1'b1;
                idle = 0;
            end
        end else idle = 0;
        #1;
        check_all(tag);
    endtask

    initial begin
        int gap;
        int sel;
        logic [7:0] b;

        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        model_reset();
        #1;
        check_all("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold");
        rst_n = 1'b1;
        step(1'b0, 8'h00, "post_reset");

        // Two make codes accumulate held keys
        step(1'b1, 8'hE0, "mk_left_e0");
        step(1'b1, 8'h6B, "mk_left");
        chk("left_set", {7'b0, left}, 8'h01);
        step(1'b1, 8'hE0, "mk_down_e0");
        chk("down_early", {7'b0, down}, 8'h00);
        step(1'b1, 8'h72, "mk_down");
        chk("down_set", {7'b0, down}, 8'h01);
        chk("left_kept", {7'b0, left}, 8'h01);

        // Break of held key, then redundant break of a clear key
        step(1'b1, 8'hE0, "brk_left_e0");
        step(1'b1, 8'hF0, "brk_left_f0");
        step(1'b1, 8'h6B, "brk_left");
        chk("left_clear", {7'b0, left}, 8'h00);
        step(1'b1, 8'hE0, "brk_up_e0");
        step(1'b1, 8'hF0, "brk_up_f0");
        step(1'b1, 8'h75, "brk_up_redundant");

        // Unknown extended code and plain bytes, then a valid make
        step(1'b1, 8'hE0, "unk_e0");
        step(1'b1, 8'h68, "unk_68");
        step(1'b1, 8'hD4, "plain_d4");
        step(1'b1, 8'h06, "plain_06");
        step(1'b1, 8'hE0, "mk_right_e0");
        step(1'b1, 8'h74, "mk_right");
        chk("right_set", {7'b0, right}, 8'h01);

        // Bare break consumes the arrow code without effect
        step(1'b1, 8'hF0, "bare_f0");
        step(1'b1, 8'h74, "bare_74");
        chk("right_kept", {7'b0, right}, 8'h01);

        // Timeout: TO idle cycles abort, trailing byte ignored from IDLE
        step(1'b1, 8'hE0, "to_e0");
        for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00, "to_wait");
        chk("to_not_yet", {7'b0, seq_timeout}, 8'h00);
        step(1'b0, 8'h00, "to_fire");
        chk("to_pulse", {7'b0, seq_timeout}, 8'h01);
        step(1'b1, 8'h75, "to_after");
        chk("to_pulse_once", {7'b0, seq_timeout}, 8'h00);
        chk("to_up_ignored", {7'b0, up}, 8'h00);

        // Byte on the final allowed cycle wins over the timeout
        step(1'b1, 8'hE0, "race_e0");
        for (int i = 0; i < TO - 1; i++) step(1'b0, 8'h00, "race_wait");
        step(1'b1, 8'h75, "race_byte");
        chk("race_up_set", {7'b0, up}, 8'h01);
        chk("race_no_pulse", {7'b0, seq_timeout}, 8'h00);

        // Clear-all with several keys held
        step(1'b1, 8'hE0, "aa_left_e0");
        step(1'b1, 8'h6B, "aa_left");
        step(1'b1, 8'hAA, "aa");
        chk("aa_all_clear", {4'b0, up, right, down, left}, 8'h00);
        step(1'b0, 8'h00, "aa_after");

        // Reset mid-sequence discards the prefix
        step(1'b1, 8'hE0, "rst_e0");
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_mid_async");
        @(posedge clk);
        #1;
        check_all("rst_mid_hold");
        rst_n = 1'b1;
        step(1'b1, 8'hF0, "rst_f0");
        step(1'b1, 8'h6B, "rst_6b");
        chk("rst_left_clear", {7'b0, left}, 8'h00);

        // Random byte streams with occasional long gaps to provoke timeouts
        for (int n = 0; n < 500; n++) begin
            gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                              : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step(1'b0, 8'($urandom), "rnd_idle");
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    b = 8'hE0;
                2:       b = 8'hF0;
                3:       b = 8'hAA;
                4:       b = 8'h6B;
                5:       b = 8'h72;
                6:       b = 8'h74;
                7:       b = 8'h75;
                default: b = 8'($urandom);
            endcase
            step(1'b1, b, "rnd_byte");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
